// File: rtl/fpu_add_sched.sv
// Round-robin scheduler that shares one pipelined FP32 adder among N requesters.
// A tag pipe tracks the owner of each in-flight add so each sum returns with its ID.
module fpu_add_sched #(
   parameter int N       = 4,
   parameter int ADD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   input  logic [N*32-1:0]   req_a,
   input  logic [N*32-1:0]   req_b,
   output logic [N-1:0]      req_ready,
   output logic [31:0]       add_ip1,
   output logic [31:0]       add_ip2,
   input  logic [31:0]       add_result,
   output logic              rsp_valid,
   output logic [((N>1)?$clog2(N):1)-1:0] rsp_id,
   output logic [31:0]       rsp_result,
   output logic              busy
);

   localparam int IDW = (N > 1) ? $clog2(N) : 1;

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] gnt_id;
   logic           gnt_any;
   logic [N-1:0]   grant;
   logic [31:0]    sel_a;
   logic [31:0]    sel_b;
   logic [IDW-1:0] ptr_next;

   logic [ADD_LAT:0] tag_vld;
   logic [IDW-1:0]   tag_id [ADD_LAT+1];

   // Arbitration: first valid requester scanning from ptr with wrap-around.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      grant   = '0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(ptr) + k) % N;
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = IDW'(idx);
         end
      end
      if (rst)
         gnt_any = 1'b0;
      if (gnt_any)
         grant[gnt_id] = 1'b1;
   end

   assign req_ready = grant;
   assign sel_a     = req_a[32*gnt_id +: 32];
   assign sel_b     = req_b[32*gnt_id +: 32];
   assign ptr_next  = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;
   assign busy      = |tag_vld;

   // Operand registers and tag stage 0 load on the accept edge; the tag pipe never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= '0;
         add_ip1    <= '0;
         add_ip2    <= '0;
         tag_vld    <= '0;
         for (int s = 0; s <= ADD_LAT; s++)
            tag_id[s] <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
      end else begin
         if (gnt_any)
            ptr <= ptr_next;
         add_ip1    <= gnt_any ? sel_a : 32'd0;
         add_ip2    <= gnt_any ? sel_b : 32'd0;
         tag_vld[0] <= gnt_any;
         tag_id[0]  <= gnt_id;
         for (int s = 1; s <= ADD_LAT; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_id[s]  <= tag_id[s-1];
         end
         // Output stage: the adder's sum is valid exactly when the last tag stage is.
         rsp_valid <= tag_vld[ADD_LAT];
         if (tag_vld[ADD_LAT]) begin
            rsp_id     <= tag_id[ADD_LAT];
            rsp_result <= add_result;
         end
      end
   end

endmodule

// File: tb/tb_fpu_add_sched.sv
// Bench for fpu_add_sched: directed scenarios plus randomized traffic against a
// queue-based reference model and a behavioural one-cycle FP32 adder.
module tb_fpu_add_sched;

   localparam int N       = 4;
   localparam int ADD_LAT = 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*32-1:0] req_a;
   logic [N*32-1:0] req_b;
   logic [N-1:0]   req_ready;
   logic [31:0]    add_ip1;
   logic [31:0]    add_ip2;
   logic [31:0]    add_result;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [31:0]    rsp_result;
   logic           busy;

   fpu_add_sched #(.N(N), .ADD_LAT(ADD_LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .add_ip1(add_ip1), .add_ip2(add_ip2),
      .add_result(add_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0)
         d = {f[31], 63'd0};
      else if (f[30:23] == 8'hFF)
         d = {f[31], 11'h7FF, f[22:0], 29'd0};
      else
         d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      logic [10:0] t;
      d = $realtobits(r);
      e = d[62:52];
      t = e - 11'd896;
      if (e == 11'h7FF)     return {d[63], 8'hFF, d[51:29]};
      else if (e <= 11'd896) return {d[63], 31'd0};
      else if (e >= 11'd1151) return {d[63], 8'hFF, 23'd0};
      else                  return {d[63], t[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return r2f(f2r(a) + f2r(b));
   endfunction

   function automatic logic [31:0] rnd_fp();
      return {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
   endfunction

   // Behavioural adder with one edge of latency.
   always @(posedge clk) add_result <= fadd(add_ip1, add_ip2);

   typedef struct {
      int          id;
      logic [31:0] res;
      int          due;
   } ent_t;

   ent_t        expq[$];
   int          mptr;
   int          cyc;
   logic [1:0]  last_id;
   logic [31:0] last_res;
   int          checks;
   int          errors;
   int          exp_grant;
   logic [3:0]  ready_seen;
   int          rsp_cnt;
   logic [3:0]  pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic step(input logic r, input logic [3:0] v);
      logic [3:0]  eg;
      logic [31:0] ea;
      logic [31:0] eb;
      ent_t        e;
      int          g;
      rst = r;
      req_valid = v;
      #1;
      g = -1;
      if (!r)
         for (int k = 0; k < N; k++)
            if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
      eg = (g >= 0) ? 4'(1 << g) : 4'b0000;
      ready_seen = req_ready;
      chk("req_ready", 32'(req_ready), 32'(eg));
      exp_grant = g;
      ea = 32'd0;
      eb = 32'd0;
      if (g >= 0) begin
         ea = req_a[32*g +: 32];
         eb = req_b[32*g +: 32];
         e.id  = g;
         e.res = fadd(ea, eb);
         e.due = cyc + 1 + ADD_LAT + 1;
         expq.push_back(e);
         mptr = (g + 1) % N;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (r) begin
         expq.delete();
         mptr = 0;
         last_id = 2'd0;
         last_res = 32'd0;
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
         last_id  = 2'(expq[0].id);
         last_res = expq[0].res;
         void'(expq.pop_front());
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
      end else begin
         chk("rsp_valid", 32'(rsp_valid), 32'd0);
      end
      if (rsp_valid === 1'b1) rsp_cnt++;
      chk("rsp_id", 32'(rsp_id), 32'(last_id));
      chk("rsp_result", rsp_result, last_res);
      chk("busy", 32'(busy), 32'(expq.size() > 0));
      chk("add_ip1", add_ip1, ea);
      chk("add_ip2", add_ip2, eb);
   endtask

   initial begin
      int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      checks = 0; errors = 0; cyc = 0; mptr = 0; rsp_cnt = 0;
      last_id = 2'd0; last_res = 32'd0;
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;

      // Reset held two cycles; grants must stay off even with all requests valid.
      step(1'b1, 4'b0000);
      step(1'b1, 4'b1111);
      chk("rst_ready", 32'(ready_seen), 32'd0);
      step(1'b0, 4'b0000);

      // Single request 1.5 + 3.0.
      set_op(0, 32'h3FC00000, 32'h40400000);
      step(1'b0, 4'b0001);
      chk("t2_busy", 32'(busy), 32'd1);
      step(1'b0, 4'b0000);
      step(1'b0, 4'b0000);
      chk("t2_valid", 32'(rsp_valid), 32'd1);
      chk("t2_id", 32'(rsp_id), 32'd0);
      chk("t2_result", rsp_result, 32'h40900000);
      step(1'b0, 4'b0000);

      // All four requesting for eight cycles.
      step(1'b1, 4'b0000);
      for (int i = 0; i < N; i++) set_op(i, rnd_fp(), rnd_fp());
      rsp_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 4'b1111);
         chk("t3_grant", 32'(ready_seen), 32'(1 << order[i]));
         if (exp_grant >= 0) set_op(exp_grant, rnd_fp(), rnd_fp());
      end
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
      chk("t3_rsp_count", 32'(rsp_cnt), 32'd8);

      // Fairness: grant 1, idle, then 1001 gives 3 then 0.
      set_op(1, rnd_fp(), rnd_fp());
      step(1'b0, 4'b0010);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
      set_op(0, rnd_fp(), rnd_fp());
      set_op(3, rnd_fp(), rnd_fp());
      step(1'b0, 4'b1001);
      chk("t4_grant3", 32'(ready_seen), 32'b1000);
      set_op(3, rnd_fp(), rnd_fp());
      step(1'b0, 4'b1001);
      chk("t4_grant0", 32'(ready_seen), 32'b0001);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);

      // Mixed data: move ptr to 2, then id 2 (3.5+5.5) before id 1 (4.2-12.3).
      set_op(1, rnd_fp(), rnd_fp());
      step(1'b0, 4'b0010);
      set_op(2, 32'h40600000, 32'h40B00000);
      set_op(1, 32'h40866666, 32'hC144CCCD);
      step(1'b0, 4'b0110);
      chk("t5_grant2", 32'(ready_seen), 32'b0100);
      step(1'b0, 4'b0010);
      step(1'b0, 4'b0000);
      chk("t5_id2", 32'(rsp_id), 32'd2);
      chk("t5_res2", rsp_result, 32'h41100000);
      step(1'b0, 4'b0000);
      chk("t5_id1", 32'(rsp_id), 32'd1);
      chk("t5_valid1", 32'(rsp_valid), 32'd1);
      step(1'b0, 4'b0000);

      // Reset with two adds in flight.
      set_op(3, rnd_fp(), rnd_fp());
      step(1'b0, 4'b1000);
      set_op(0, rnd_fp(), rnd_fp());
      step(1'b0, 4'b0001);
      rsp_cnt = 0;
      step(1'b1, 4'b0000);
      chk("t6_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
      chk("t6_no_rsp", 32'(rsp_cnt), 32'd0);
      for (int i = 0; i < N; i++) set_op(i, rnd_fp(), rnd_fp());
      step(1'b0, 4'b1111);
      chk("t6_grant0", 32'(ready_seen), 32'b0001);
      step(1'b0, 4'b0000);
      step(1'b0, 4'b0000);

      // Randomized traffic obeying the hold-until-accepted rule, with occasional resets.
      pend = 4'b0000;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               set_op(i, rnd_fp(), rnd_fp());
            end
         step(($urandom_range(0, 60) == 0), pend);
         if (exp_grant >= 0) pend[exp_grant] = 1'b0;
      end
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
